cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Sequences and shares the single main-memory port (`mem_ren`/`mem_wen`/`mem_addr`/`mem_din`/`mem_dout`) between two cache controllers: requester 0 (instruction cache) and requester 1 (data cache). Each request is one full-line burst, either a refill (read) or a writeback (write). Arbitration is round-robin, and each burst runs to completion without interruption. The block sits between the cache instances and the memory model/bus in the top level.

## Interface
Parameters:
- `BURST`, 4: words per line transfer; power of 2, ≥2.
- `MEM_LAT`, 2: cycles from `mem_ren` to valid `mem_dout`; ≥1.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req0`/`req1` in 1: transfer request; level, held until `done` (see Operation).
- `we0`/`we1` in 1: 1 = writeback, 0 = refill; sampled with `req`.
- `addr0`/`addr1` in 32: byte address within the line; sampled with `req`.
- `wdata0`/`wdata1` in 32: current write word; advanced by requester after each `wack`.
- `gnt0`/`gnt1` out 1: high for the whole burst owned by that requester.
- `wack0`/`wack1` out 1: write word consumed this cycle.
- `rvalid0`/`rvalid1` out 1: `rdata` holds the next refill word.
- `rdata` out 32: registered refill data, shared by both requesters.
- `done0`/`done1` out 1: one-cycle pulse on the final word of the burst.
- `mem_ren`, `mem_wen` out 1: memory read/write strobes.
- `mem_addr` out 32: word-aligned memory byte address.
- `mem_din` out 32: write data to memory.
- `mem_dout` in 32: read data from memory, valid `MEM_LAT` cycles after `mem_ren`.

## Operation
- FSM states: IDLE, RD, WR.
- **Reset (`rst`=0):** state IDLE; round-robin pointer set so requester 0 wins the first tie. All outputs are 0: `gnt*`, `wack*`, `rvalid*`, `done*`, `mem_ren`, `mem_wen`, `mem_addr`, `mem_din`, `rdata`. All counters and the valid pipeline are cleared.
- **IDLE:**
  - If exactly one `req` is high, grant it.
  - If both are high, grant the one not served last.
  - On grant, latch the owner id, `we`, and `base = addr & ~(BURST*4-1)`. Go to WR if `we`=1, else RD. Assert `gnt` from the next cycle.
- **WR:**
  - Cycle i (i = 0..BURST-1): `mem_wen`=1, `mem_addr = base + 4*i`, `mem_din = wdata_owner`, `wack_owner`=1.
  - On i = BURST-1: `done_owner`=1, next state IDLE.
- **RD issue:** cycles i = 0..BURST-1: `mem_ren`=1, `mem_addr = base + 4*i`, one issue per cycle, no stalls.
- **RD return:**
  - A `MEM_LAT`-deep valid shift register tracks outstanding reads.
  - When a valid reaches the end, register `mem_dout` into `rdata` and assert `rvalid_owner` the following cycle.
  - Words return in address order.
  - `done_owner` coincides with the BURST-th `rvalid`; next state IDLE.
- **Counters:** issue and return counters are each `log2(BURST)+1` bits wide. Address arithmetic is modulo 2^32. Bursts are always line-aligned; no critical-word-first.
- **Round-robin update:** the pointer updates at `done`; the last-served requester gets lowest priority.
- **Request handling:**
  - `req`, `addr`, `we` changes during a burst are ignored.
  - Dropping `req` mid-burst does not abort it.
  - `req` still high in the IDLE cycle after `done` is treated as a new request.
- The non-owner's `gnt`/`wack`/`rvalid`/`done` stay 0 throughout.
- `mem_ren` and `mem_wen` are never high together.
- **Reset mid-burst:** all outputs drop to 0 asynchronously. In-flight read data is discarded; no `rvalid` follows reset release.

## Timing
- Request sampled in IDLE at cycle 0; first memory strobe and `gnt` at cycle 1.
- **Write:** strobes and `wack` in cycles 1..BURST; `done` in cycle BURST; IDLE in cycle BURST+1. Occupancy is BURST+1 cycles.
- **Read:** issues in cycles 1..BURST; `rvalid` in cycles 2+MEM_LAT..BURST+1+MEM_LAT; `done` in the last of these; IDLE the next cycle.
- Arbitration takes 1 cycle (IDLE) between bursts; there is no back-to-back overlap.
- All outputs are registered or decoded from registered state only. There is no combinational path from `req*` or `mem_dout` to any output.

## Test plan
1. **Single read.** BURST=4, MEM_LAT=2; `req0`=1, `we0`=0, `addr0`=0x104 at cycle 0. Required:
   - `mem_addr` = 0x100/0x104/0x108/0x10C with `mem_ren` in cycles 1–4.
   - `rvalid0` in cycles 4–7, with `rdata` = memory contents in order.
   - `done0` in cycle 7; `gnt0` low in cycle 8.
2. **Single write.** `req1`, `we1`=1, `addr1`=0x2F8, `wdata1` sequence A0..A3. Required:
   - `mem_wen` in cycles 1–4 at 0x2F0..0x2FC with `mem_din` = A0..A3.
   - `wack1` in cycles 1–4; `done1` in cycle 4.
3. **Simultaneous requests after reset.** Both `req` high. Required: requester 0 is served first; requester 1 is granted at the next IDLE.
4. **Continuous contention.** Both requesters held high for 4 bursts. Required: grants alternate 0,1,0,1; `gnt0` and `gnt1` are never high together.
5. **`req` dropped mid-burst.** `req0` deasserted in cycle 2 of a read. Required: the burst completes with all 4 `rvalid0` and `done0`.
6. **Reset mid-burst.** `rst` asserted in cycle 3 of a read. Required:
   - All outputs are 0 immediately.
   - After release with no `req`: no `rvalid`, and `mem_ren` stays 0.
   - A subsequent `req1` is served normally.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cache_mem_arbiter
//  Description : Round-robin line-burst arbiter sharing one memory port
//                between the instruction cache (0) and data cache (1).
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
    parameter int BURST   = 4,
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        wack0,
    output logic        wack1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata,
    output logic        done0,
    output logic        done1,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    localparam int            CW        = $clog2(BURST) + 1;
    localparam logic [CW-1:0] LAST      = CW'(BURST - 1);
    localparam logic [31:0]   LINE_MASK = ~(32'(BURST * 4) - 32'd1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               grant_id;
    logic               owner;
    logic               last_srv;
    logic [31:0]        base;
    logic [CW-1:0]      issue_cnt;
    logic [CW-1:0]      ret_cnt;
    logic [MEM_LAT-1:0] vpipe;
    logic               rv;
    logic [31:0]        rdata_q;
    logic               issuing;
    logic               wr_act;
    logic               wr_last;
    logic               last_ret;
    logic               done;
    logic               busy;

    // BURST is a power of two, so the counter MSB marks "all words issued".
    assign issuing  = (state == RD) && !issue_cnt[CW-1];
    assign wr_act   = (state == WR);
    assign wr_last  = wr_act && (issue_cnt == LAST);
    assign last_ret = (state == RD) && rv && (ret_cnt == LAST);
    assign done     = wr_last || last_ret;
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        grant_id  = (req0 && req1) ? ~last_srv : req1;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nxt = (grant_id ? we1 : we0) ? WR : RD;
                end
            end
            RD:      if (last_ret) state_nxt = IDLE;
            WR:      if (wr_last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner     <= 1'b0;
            last_srv  <= 1'b1;
            base      <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            vpipe     <= '0;
            rv        <= 1'b0;
            rdata_q   <= '0;
        end else begin
            // Each stage marks a read still in flight in the memory pipeline.
            vpipe <= (vpipe << 1) | MEM_LAT'(issuing);
            rv    <= vpipe[MEM_LAT-1];
            if (vpipe[MEM_LAT-1]) begin
                rdata_q <= mem_dout;
            end
            if ((state == IDLE) && (state_nxt != IDLE)) begin
                owner     <= grant_id;
                base      <= (grant_id ? addr1 : addr0) & LINE_MASK;
                issue_cnt <= '0;
                ret_cnt   <= '0;
            end else begin
                if (issuing || wr_act) begin
                    issue_cnt <= issue_cnt + 1'b1;
                end
                if (rv) begin
                    ret_cnt <= ret_cnt + 1'b1;
                end
            end
            if (done) begin
                last_srv <= owner;
            end
        end
    end

    assign gnt0     = busy && !owner;
    assign gnt1     = busy &&  owner;
    assign wack0    = wr_act && !owner;
    assign wack1    = wr_act &&  owner;
    assign rvalid0  = rv && !owner;
    assign rvalid1  = rv &&  owner;
    assign done0    = done && !owner;
    assign done1    = done &&  owner;
    assign rdata    = rdata_q;
    assign mem_ren  = issuing;
    assign mem_wen  = wr_act;
    assign mem_addr = (issuing || wr_act) ? (base + (32'(issue_cnt) << 2)) : '0;
    assign mem_din  = wr_act ? (owner ? wdata1 : wdata0) : '0;

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_mem_arbiter
//  Description : Directed self-checking bench for cache_mem_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cache_mem_arbiter;

    localparam int BURST   = 4;
    localparam int MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, wack0, wack1, rvalid0, rvalid1, done0, done1;
    logic        mem_ren, mem_wen;
    logic [31:0] rdata, mem_addr, mem_din, mem_dout;
    logic [31:0] d1 = '0, d2 = '0;
    logic        overlap_seen = 1'b0;

    int checks = 0;
    int errors = 0;

    cache_mem_arbiter #(.BURST(BURST), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .wack0(wack0), .wack1(wack1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .done0(done0), .done1(done1),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Memory returns addr ^ 0xDEAD0000, two cycles after the read strobe.
    always @(posedge clk) begin
        d1 <= mem_ren ? (mem_addr ^ 32'hDEAD0000) : 32'h0;
        d2 <= d1;
    end
    assign mem_dout = d2;

    always @(negedge clk) begin
        if ((gnt0 && gnt1) || (mem_ren && mem_wen)) overlap_seen = 1'b1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 100000", $time);
        $fatal(1);
    end

    initial begin
        int nrv;
        int ndone;
        int nren;
        int k;
        logic [9:0] ctl;

        // Reset state
        step();
        ctl = {gnt0, gnt1, wack0, wack1, rvalid0, rvalid1, done0, done1, mem_ren, mem_wen};
        check_val("rst_ctl", 32'(ctl), 32'h0);
        check_val("rst_addr", mem_addr, 32'h0);
        check_val("rst_rdata", rdata, 32'h0);
        step();
        rst = 1'b1;

        // Test 1: single read of line 0x100
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h104;
        for (int c = 1; c <= 8; c++) begin
            step();
            check_val("t1_ren", 32'(mem_ren), 32'(c <= 4));
            if (c <= 4) check_val("t1_addr", mem_addr, 32'h100 + 4 * (c - 1));
            check_val("t1_rvalid0", 32'(rvalid0), 32'(c >= 4 && c <= 7));
            if (c >= 4 && c <= 7) check_val("t1_rdata", rdata, 32'hDEAD0100 + 4 * (c - 4));
            check_val("t1_done0", 32'(done0), 32'(c == 7));
            check_val("t1_gnt0", 32'(gnt0), 32'(c <= 7));
            check_val("t1_rvalid1", 32'(rvalid1), 32'h0);
            if (c == 7) req0 = 1'b0;
        end

        // Test 2: single write from requester 1
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h2F8; wdata1 = 32'hA0;
        for (int c = 1; c <= 5; c++) begin
            step();
            check_val("t2_wen", 32'(mem_wen), 32'(c <= 4));
            if (c <= 4) begin
                check_val("t2_addr", mem_addr, 32'h2F0 + 4 * (c - 1));
                check_val("t2_din", mem_din, 32'hA0 + (c - 1));
            end
            check_val("t2_wack1", 32'(wack1), 32'(c <= 4));
            check_val("t2_wack0", 32'(wack0), 32'h0);
            check_val("t2_done1", 32'(done1), 32'(c == 4));
            check_val("t2_gnt1", 32'(gnt1), 32'(c <= 4));
            wdata1 = 32'hA0 + c;
            if (c == 4) req1 = 1'b0;
        end

        // Test 3: simultaneous requests right after reset
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h80; wdata1 = 32'h55;
        for (int c = 1; c <= 13; c++) begin
            step();
            if (c == 1) begin
                check_val("t3_gnt0_first", 32'(gnt0), 32'h1);
                check_val("t3_gnt1_first", 32'(gnt1), 32'h0);
                check_val("t3_addr_first", mem_addr, 32'h40);
            end
            if (c == 7) begin
                check_val("t3_done0", 32'(done0), 32'h1);
                req0 = 1'b0;
            end
            if (c == 8) check_val("t3_idle_gap", 32'({gnt0, gnt1}), 32'h0);
            if (c == 9) begin
                check_val("t3_gnt1_second", 32'(gnt1), 32'h1);
                check_val("t3_wen", 32'(mem_wen), 32'h1);
                check_val("t3_addr_second", mem_addr, 32'h80);
                check_val("t3_din", mem_din, 32'h55);
            end
            if (c == 12) begin
                check_val("t3_done1", 32'(done1), 32'h1);
                req1 = 1'b0;
            end
        end

        // Test 4: continuous contention, write bursts alternate
        do_reset();
        overlap_seen = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h1000;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h2000;
        for (int c = 1; c <= 20; c++) begin
            step();
            if ((c - 1) % 5 == 0) begin
                k = (c - 1) / 5;
                check_val("t4_gnt0", 32'(gnt0), 32'(k % 2 == 0));
                check_val("t4_gnt1", 32'(gnt1), 32'(k % 2 == 1));
                check_val("t4_addr", mem_addr, (k % 2 == 0) ? 32'h1000 : 32'h2000);
            end
            if (c == 19) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        check_val("t4_no_overlap", 32'(overlap_seen), 32'h0);

        // Test 5: req0 dropped mid-burst
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20C;
        nrv = 0; ndone = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (rvalid0) begin
                check_val("t5_rdata", rdata, 32'hDEAD0200 + 4 * nrv);
                nrv++;
            end
            if (done0) ndone++;
            if (c == 2) req0 = 1'b0;
        end
        check_val("t5_rvalid_cnt", 32'(nrv), 32'd4);
        check_val("t5_done_cnt", 32'(ndone), 32'd1);

        // Test 6: reset in the middle of a read
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h300;
        step(); step(); step();
        check_val("t6_ren_before", 32'(mem_ren), 32'h1);
        rst = 1'b0;
        req0 = 1'b0;
        #1;
        ctl = {gnt0, gnt1, wack0, wack1, rvalid0, rvalid1, done0, done1, mem_ren, mem_wen};
        check_val("t6_ctl_zero", 32'(ctl), 32'h0);
        check_val("t6_addr_zero", mem_addr, 32'h0);
        check_val("t6_din_zero", mem_din, 32'h0);
        check_val("t6_rdata_zero", rdata, 32'h0);
        step(); step();
        #3 rst = 1'b1;
        nrv = 0; nren = 0;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (rvalid0 || rvalid1) nrv++;
            if (mem_ren) nren++;
        end
        check_val("t6_no_rvalid", 32'(nrv), 32'h0);
        check_val("t6_no_ren", 32'(nren), 32'h0);
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h500;
        nrv = 0; ndone = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c == 1) check_val("t6_gnt1", 32'(gnt1), 32'h1);
            if (rvalid1) begin
                check_val("t6_rdata", rdata, 32'hDEAD0500 + 4 * nrv);
                nrv++;
            end
            if (done1) begin
                ndone++;
                req1 = 1'b0;
            end
        end
        check_val("t6_rvalid_cnt", 32'(nrv), 32'd4);
        check_val("t6_done_cnt", 32'(ndone), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
